// File: rtl/conv_out_buf_writer.sv
// Output-buffer writer: turns the conv handler's 1-based row stream into buffer addresses, decouples it via a show-ahead FIFO.
// Optional macro CONV_OUT_BUF_WRITER_ADR_CHECK_EN adds out-of-range address screening and the sticky adr_err output.
module conv_out_buf_writer #(
   parameter int unsigned out_data_width        = 256,
   parameter int unsigned pixels_in_row_in_2pow = 5,
   parameter int unsigned fifo_depth_in_2pow    = 3,
   parameter int unsigned buf_depth             = 16384
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          mode,
   input  logic                          in_valid,
   input  logic [15:0]                   in_y_idx,
   input  logic [15:0]                   in_x_idx,
   input  logic [15:0]                   in_f_idx,
   input  logic [out_data_width-1:0]     in_data,
   input  logic                          in_tile_end,
   input  logic [3:0]                    of_in_2pow,
   input  logic [3:0]                    ox_in_2pow,
   input  logic                          buf_wr_ready,
   output logic                          buf_wr_en,
   output logic [15:0]                   buf_wr_adr,
   output logic [out_data_width-1:0]     buf_wr_data,
   output logic                          tile_wr_done,
   output logic [fifo_depth_in_2pow:0]   fifo_count,
`ifdef CONV_OUT_BUF_WRITER_ADR_CHECK_EN
   output logic                          adr_err,
`endif
   output logic                          overflow
);

   localparam int unsigned DW    = out_data_width;
   localparam int unsigned PW    = fifo_depth_in_2pow;
   localparam int unsigned CW    = fifo_depth_in_2pow + 1;
   localparam int unsigned DEPTH = 1 << fifo_depth_in_2pow;
   localparam int unsigned SHW   = 6;

   typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_DONE} state_t;

   logic [SHW-1:0] sh_sum, y_sh;
   logic [15:0]    y_m1, x_m1, f_m1, x_scaled, adr_c;

   logic           a_valid_q, a_valid_d, a_tend_q, a_tend_d, a_mode_q, a_mode_d, a_nowr_q, a_nowr_d;
   logic [15:0]    a_adr_q, a_adr_d;
   logic [DW-1:0]  a_data_q, a_data_d;

   logic [15:0]    fifo_adr_q  [DEPTH];
   logic [DW-1:0]  fifo_data_q [DEPTH];
   logic           fifo_tend_q [DEPTH];
   logic           fifo_mode_q [DEPTH];
   logic           fifo_nowr_q [DEPTH];

   logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  fifo_count_q, fifo_count_d, tend_cnt_q, tend_cnt_d;
   logic           overflow_q, overflow_d, tile_wr_done_q, tile_wr_done_d;
   state_t         state_q, state_d;

   logic           empty, full, pop, push, head_nowr, head_tend, pop_tend, push_tend;
   logic           unused_mode;

`ifdef CONV_OUT_BUF_WRITER_ADR_CHECK_EN
   logic           adr_err_q, adr_err_d;
`else
   localparam int unsigned unused_buf_depth = buf_depth;
`endif

   // Row address: y selects a block of (of*ox/pixels) rows, x steps within it, f is the innermost offset.
   always_comb begin
      sh_sum   = SHW'(of_in_2pow) + SHW'(ox_in_2pow);
      y_sh     = (sh_sum >= SHW'(pixels_in_row_in_2pow)) ? sh_sum - SHW'(pixels_in_row_in_2pow) : '0;
      y_m1     = in_y_idx - 16'd1;
      x_m1     = in_x_idx - 16'd1;
      f_m1     = in_f_idx - 16'd1;
      x_scaled = x_m1 << of_in_2pow;
      adr_c    = (y_m1 << y_sh) + (x_scaled >> pixels_in_row_in_2pow) + f_m1;
   end

   // Stage A capture; an out-of-range tile-end row survives as a no-write marker.
   always_comb begin
      a_valid_d = 1'b0;
      a_adr_d   = a_adr_q;
      a_data_d  = a_data_q;
      a_tend_d  = a_tend_q;
      a_mode_d  = a_mode_q;
      a_nowr_d  = a_nowr_q;
`ifdef CONV_OUT_BUF_WRITER_ADR_CHECK_EN
      adr_err_d = adr_err_q;
`endif
      if (in_valid) begin
         a_valid_d = 1'b1;
         a_adr_d   = adr_c;
         a_data_d  = in_data;
         a_tend_d  = in_tile_end;
         a_mode_d  = mode;
         a_nowr_d  = 1'b0;
`ifdef CONV_OUT_BUF_WRITER_ADR_CHECK_EN
         if (32'(adr_c) >= buf_depth) begin
            adr_err_d = 1'b1;
            a_valid_d = in_tile_end;
            a_adr_d   = '0;
            a_data_d  = '0;
            a_nowr_d  = 1'b1;
         end
`endif
      end
   end

   // FIFO bookkeeping and tile-done sequencing.
   always_comb begin
      empty     = (fifo_count_q == '0);
      full      = (fifo_count_q == CW'(DEPTH));
      head_nowr = fifo_nowr_q[rd_ptr_q];
      head_tend = fifo_tend_q[rd_ptr_q];
      pop       = !empty && (buf_wr_ready || head_nowr);
      push      = a_valid_q && (!full || pop);
      pop_tend  = pop && head_tend;
      push_tend = push && a_tend_q;

      overflow_d   = overflow_q | (a_valid_q && full && !pop);
      rd_ptr_d     = rd_ptr_q + PW'(pop);
      wr_ptr_d     = wr_ptr_q + PW'(push);
      fifo_count_d = fifo_count_q;
      if (push && !pop)      fifo_count_d = fifo_count_q + CW'(1);
      else if (pop && !push) fifo_count_d = fifo_count_q - CW'(1);
      tend_cnt_d = tend_cnt_q + CW'(push_tend) - CW'(pop_tend);

      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (tend_cnt_d != '0) state_d = ST_DRAIN;
         ST_DRAIN: if (pop_tend) state_d = ST_DONE;
         ST_DONE: begin
            if (pop_tend)               state_d = ST_DONE;
            else if (tend_cnt_d != '0) state_d = ST_DRAIN;
            else                        state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
      tile_wr_done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_valid_q      <= 1'b0;
         a_adr_q        <= '0;
         a_data_q       <= '0;
         a_tend_q       <= 1'b0;
         a_mode_q       <= 1'b0;
         a_nowr_q       <= 1'b0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         fifo_count_q   <= '0;
         tend_cnt_q     <= '0;
         overflow_q     <= 1'b0;
         tile_wr_done_q <= 1'b0;
         state_q        <= ST_IDLE;
`ifdef CONV_OUT_BUF_WRITER_ADR_CHECK_EN
         adr_err_q      <= 1'b0;
`endif
      end else begin
         a_valid_q      <= a_valid_d;
         a_adr_q        <= a_adr_d;
         a_data_q       <= a_data_d;
         a_tend_q       <= a_tend_d;
         a_mode_q       <= a_mode_d;
         a_nowr_q       <= a_nowr_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         fifo_count_q   <= fifo_count_d;
         tend_cnt_q     <= tend_cnt_d;
         overflow_q     <= overflow_d;
         tile_wr_done_q <= tile_wr_done_d;
         state_q        <= state_d;
`ifdef CONV_OUT_BUF_WRITER_ADR_CHECK_EN
         adr_err_q      <= adr_err_d;
`endif
      end
   end

   // Storage needs no reset: reads are masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_adr_q[wr_ptr_q]  <= a_adr_q;
         fifo_data_q[wr_ptr_q] <= a_data_q;
         fifo_tend_q[wr_ptr_q] <= a_tend_q;
         fifo_mode_q[wr_ptr_q] <= a_mode_q;
         fifo_nowr_q[wr_ptr_q] <= a_nowr_q;
      end
   end

   assign buf_wr_en    = !empty && !head_nowr;
   assign buf_wr_adr   = empty ? '0 : fifo_adr_q[rd_ptr_q];
   assign buf_wr_data  = empty ? '0 : fifo_data_q[rd_ptr_q];
   assign tile_wr_done = tile_wr_done_q;
   assign fifo_count   = fifo_count_q;
   assign overflow     = overflow_q;
   assign unused_mode  = fifo_mode_q[rd_ptr_q];
`ifdef CONV_OUT_BUF_WRITER_ADR_CHECK_EN
   assign adr_err      = adr_err_q;
`endif

endmodule

// File: tb/tb_conv_out_buf_writer.sv
// Bench for conv_out_buf_writer: directed scenarios plus random traffic against a queue-based reference model.
module tb_conv_out_buf_writer;

   localparam int unsigned W = 256;
`ifdef CONV_OUT_BUF_WRITER_ADR_CHECK_EN
   localparam bit          ADR_CHK   = 1'b1;
   localparam int unsigned BUF_DEPTH = 16;
`else
   localparam bit          ADR_CHK   = 1'b0;
   localparam int unsigned BUF_DEPTH = 16384;
`endif

   logic          clk, reset, mode, in_valid, in_tile_end, buf_wr_ready;
   logic [15:0]   in_y_idx, in_x_idx, in_f_idx;
   logic [W-1:0]  in_data;
   logic [3:0]    of_in_2pow, ox_in_2pow;
   logic          buf_wr_en, tile_wr_done, overflow;
   logic [15:0]   buf_wr_adr;
   logic [W-1:0]  buf_wr_data;
   logic [3:0]    fifo_count;
`ifdef CONV_OUT_BUF_WRITER_ADR_CHECK_EN
   logic          adr_err;
`endif

   conv_out_buf_writer #(.out_data_width(W), .pixels_in_row_in_2pow(5),
                         .fifo_depth_in_2pow(3), .buf_depth(BUF_DEPTH)) dut (
      .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid),
      .in_y_idx(in_y_idx), .in_x_idx(in_x_idx), .in_f_idx(in_f_idx),
      .in_data(in_data), .in_tile_end(in_tile_end),
      .of_in_2pow(of_in_2pow), .ox_in_2pow(ox_in_2pow),
      .buf_wr_ready(buf_wr_ready), .buf_wr_en(buf_wr_en), .buf_wr_adr(buf_wr_adr),
      .buf_wr_data(buf_wr_data), .tile_wr_done(tile_wr_done), .fifo_count(fifo_count),
`ifdef CONV_OUT_BUF_WRITER_ADR_CHECK_EN
      .adr_err(adr_err),
`endif
      .overflow(overflow));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic longint pow2(input int n);
      longint p = 1;
      for (int i = 0; i < n; i++) p = p * 2;
      return p;
   endfunction

   // Reference address from 1-based indices, each term reduced mod 2^16.
   function automatic logic [15:0] exp_adr(input int unsigned y, x, f, of, ox);
      longint ym, xm, fm, t1, t2;
      int sh;
      ym = (longint'(y) + 65535) % 65536;
      xm = (longint'(x) + 65535) % 65536;
      fm = (longint'(f) + 65535) % 65536;
      sh = int'(of) + int'(ox) - 5;
      if (sh < 0) sh = 0;
      t1 = (ym * pow2(sh)) % 65536;
      t2 = ((xm * pow2(int'(of))) % 65536) / 32;
      return 16'((t1 + t2 + fm) % 65536);
   endfunction

   function automatic logic [W-1:0] rnd256();
      logic [W-1:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   typedef struct {
      logic [15:0]  adr;
      logic [W-1:0] data;
      bit           tend;
      bit           nowr;
   } ent_t;

   ent_t mq[$];
   ent_t m_a;
   bit   m_a_vld = 0, m_ovf = 0, m_pulse = 0, m_aerr = 0;
   int   cyc = 0;
   bit   chk_on = 0, mon_on = 0;
   int   n_pulse = 0, pulse_cyc = 0;
   logic [15:0] obs_adr[$];
   int          obs_cyc[$];

   // Reference model: one-cycle capture stage feeding an 8-deep queue.
   initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
         mq.delete();
         m_a_vld = 0; m_ovf = 0; m_pulse = 0; m_aerr = 0;
      end else begin
         bit pop, pop_te;
         logic [15:0] a;
         pop    = (mq.size() > 0) && (buf_wr_ready || mq[0].nowr);
         pop_te = pop && mq[0].tend;
         if (pop) void'(mq.pop_front());
         if (m_a_vld) begin
            if (mq.size() < 8) mq.push_back(m_a);
            else m_ovf = 1;
         end
         m_pulse = pop_te;
         m_a_vld = 0;
         if (in_valid) begin
            a = exp_adr(in_y_idx, in_x_idx, in_f_idx, of_in_2pow, ox_in_2pow);
            if (ADR_CHK && (int'(a) >= int'(BUF_DEPTH))) begin
               m_aerr = 1;
               if (in_tile_end) begin
                  m_a.adr = '0; m_a.data = '0; m_a.tend = 1; m_a.nowr = 1; m_a_vld = 1;
               end
            end else begin
               m_a.adr = a; m_a.data = in_data; m_a.tend = in_tile_end; m_a.nowr = 0; m_a_vld = 1;
            end
         end
      end
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Per-cycle comparison against the model, plus a handshake/pulse monitor.
   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         bit m_en;
         m_en = (mq.size() > 0) && !mq[0].nowr;
         check("wr_en", buf_wr_en, m_en);
         if (m_en) begin
            check("wr_adr", buf_wr_adr, mq[0].adr);
            check("wr_data", buf_wr_data, mq[0].data);
         end
         check("fifo_count", fifo_count, mq.size());
         check("overflow", overflow, m_ovf);
         check("tile_wr_done", tile_wr_done, m_pulse);
`ifdef CONV_OUT_BUF_WRITER_ADR_CHECK_EN
         check("adr_err", adr_err, m_aerr);
`endif
      end
      if (mon_on && buf_wr_en && buf_wr_ready) begin
         obs_adr.push_back(buf_wr_adr);
         obs_cyc.push_back(cyc);
      end
      if (mon_on && tile_wr_done) begin
         n_pulse++;
         pulse_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] y, x, f, input bit te, output logic [W-1:0] d);
      d = rnd256();
      in_valid = 1'b1; in_y_idx = y; in_x_idx = x; in_f_idx = f;
      in_tile_end = te; in_data = d;
      tick();
      in_valid = 1'b0; in_tile_end = 1'b0;
   endtask

   task automatic mon_start();
      obs_adr.delete(); obs_cyc.delete(); n_pulse = 0; mon_on = 1;
   endtask

   initial begin
      logic [W-1:0] d;
      reset = 1'b0; mode = 1'b0; in_valid = 1'b0; in_tile_end = 1'b0;
      in_y_idx = '0; in_x_idx = '0; in_f_idx = '0; in_data = '0;
      of_in_2pow = 4'd4; ox_in_2pow = 4'd5; buf_wr_ready = 1'b0;
      repeat (3) tick();
      check("rst_en", buf_wr_en, 1'b0);
      check("rst_count", fifo_count, 4'd0);
      check("rst_adr", buf_wr_adr, 16'd0);
      check("rst_data", buf_wr_data, '0);
      check("rst_ovf", overflow, 1'b0);
      check("rst_done", tile_wr_done, 1'b0);
      reset = 1'b1; buf_wr_ready = 1'b1; chk_on = 1;
      tick();

`ifndef CONV_OUT_BUF_WRITER_ADR_CHECK_EN
      // Single row, latency and address 18.
      send(16'd2, 16'd1, 16'd3, 1'b0, d);
      check("t1_en_n1", buf_wr_en, 1'b0);
      tick();
      check("t1_en_n2", buf_wr_en, 1'b1);
      check("t1_adr", buf_wr_adr, 16'd18);
      check("t1_data", buf_wr_data, d);
      tick();

      // Burst f=1..16 at x=33 gives addresses 16..31 back to back.
      ox_in_2pow = 4'd6;
      mon_start();
      for (int f = 1; f <= 16; f++) send(16'd1, 16'd33, 16'(f), 1'b0, d);
      repeat (4) tick();
      mon_on = 0;
      check("t2_nwr", obs_adr.size(), 16);
      for (int i = 0; i < obs_adr.size() && i < 16; i++) begin
         check("t2_adr", obs_adr[i], 16'(16 + i));
         check("t2_consec", obs_cyc[i] - obs_cyc[0], i);
      end

      // Ten rows into a stalled 8-deep FIFO.
      ox_in_2pow = 4'd5; buf_wr_ready = 1'b0;
      for (int i = 0; i < 10; i++) send(16'(i + 1), 16'd1, 16'd1, 1'b0, d);
      tick();
      check("t3_count", fifo_count, 4'd8);
      check("t3_ovf", overflow, 1'b1);
      mon_start();
      buf_wr_ready = 1'b1;
      repeat (12) tick();
      mon_on = 0;
      check("t3_nwr", obs_adr.size(), 8);
      for (int i = 0; i < obs_adr.size() && i < 8; i++) check("t3_adr", obs_adr[i], 16'(16 * i));

      // Three-row tile under alternating ready.
      mon_start();
      for (int k = 0; k < 14; k++) begin
         buf_wr_ready = (k % 2 == 0);
         if (k < 3) begin
            in_valid = 1'b1; in_y_idx = 16'd4; in_x_idx = 16'd1; in_f_idx = 16'(k + 1);
            in_tile_end = (k == 2); in_data = rnd256();
         end else begin
            in_valid = 1'b0; in_tile_end = 1'b0;
         end
         tick();
      end
      mon_on = 0;
      check("t4_nwr", obs_adr.size(), 3);
      check("t4_npulse", n_pulse, 1);
      if (obs_cyc.size() == 3) check("t4_pulse_cyc", pulse_cyc, obs_cyc[2] + 1);

      // Async reset with five rows queued, then a fresh row.
      buf_wr_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         buf_wr_ready = 1'b0;
         send(16'(i + 1), 16'd1, 16'd2, 1'b0, d);
      end
      tick();
      check("t5_count", fifo_count, 4'd5);
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      check("t5_rst_en", buf_wr_en, 1'b0);
      check("t5_rst_count", fifo_count, 4'd0);
      check("t5_rst_adr", buf_wr_adr, 16'd0);
      check("t5_rst_data", buf_wr_data, '0);
      check("t5_rst_ovf", overflow, 1'b0);
      @(posedge clk); #4;
      reset = 1'b1; buf_wr_ready = 1'b1;
      tick(); tick();
      check("t5_nostale", buf_wr_en, 1'b0);
      send(16'd3, 16'd2, 16'd5, 1'b0, d);
      check("t5_en_n1", buf_wr_en, 1'b0);
      tick();
      check("t5_en_n2", buf_wr_en, 1'b1);
      check("t5_adr", buf_wr_adr, 16'd36);
      check("t5_data", buf_wr_data, d);
      tick();
`else
      // Out-of-range tile-end row becomes a silent marker that still ends the tile.
      mon_start();
      send(16'd2, 16'd1, 16'd3, 1'b1, d);
      check("t6_adr_err", adr_err, 1'b1);
      tick();
      check("t6_en_n2", buf_wr_en, 1'b0);
      tick();
      check("t6_done", tile_wr_done, 1'b1);
      send(16'd1, 16'd1, 16'd2, 1'b0, d);
      repeat (3) tick();
      mon_on = 0;
      check("t6_npulse", n_pulse, 1);
      check("t6_nwr", obs_adr.size(), 1);
      if (obs_adr.size() == 1) check("t6_inrange_adr", obs_adr[0], 16'd1);
`endif

      // Random traffic against the model.
      for (int k = 0; k < 600; k++) begin
         in_valid     = ($urandom_range(0, 9) < 7);
         in_y_idx     = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
         in_x_idx     = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 70));
         in_f_idx     = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
         in_tile_end  = ($urandom_range(0, 6) == 0);
         in_data      = rnd256();
         mode         = 1'($urandom_range(0, 1));
         of_in_2pow   = 4'($urandom_range(0, 15));
         ox_in_2pow   = 4'($urandom_range(0, 15));
         buf_wr_ready = ($urandom_range(0, 9) < 6);
         tick();
      end
      in_valid = 1'b0; in_tile_end = 1'b0; buf_wr_ready = 1'b1;
      repeat (20) tick();
      check("final_count", fifo_count, 4'd0);
      chk_on = 0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_out_buf_writer.md
Name: conv_out_buf_writer

Overview:
- Sits directly downstream of the conv output handler.
- Accepts its per-row stream (valid, y/x/f indices, packed out_data, tile-end flag) and converts the 1-based indices into output-buffer row addresses.
- Decouples the stream through a small FIFO, because the handler has no backpressure, and drives a valid/ready write port into the output buffer.
- Pulses tile_wr_done once the last row of a tile has actually been written.

Parameters:
- out_data_width, 256, bits per output row (8b x 2 pixel x 1 weight x 16 columns).
- pixels_in_row_in_2pow, 5, log2 of pixels per buffer row.
- fifo_depth_in_2pow, 3, log2 of FIFO entries (default 8).
- buf_depth, 16384, output-buffer rows; used only by the optional feature.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- mode  in  1  0: 8x8 mode, 1: 1x8 mode; informational, latched per entry.
- in_valid  in  1  row valid from the handler (valid_rowi_out_buf_adr).
- in_y_idx  in  16  1-based output y.
- in_x_idx  in  16  1-based output x start.
- in_f_idx  in  16  1-based output channel.
- in_data  in  out_data_width  row payload.
- in_tile_end  in  1  last row of tile, qualified by in_valid.
- of_in_2pow  in  4  log2 of output channels.
- ox_in_2pow  in  4  log2 of output width.
- buf_wr_ready  in  1  buffer accepts a write this cycle.
- buf_wr_en  out  1  write valid.
- buf_wr_adr  out  16  buffer row address.
- buf_wr_data  out  out_data_width  write data.
- tile_wr_done  out  1  one-cycle pulse.
- fifo_count  out  fifo_depth_in_2pow+1  current occupancy.
- overflow  out  1  sticky; a row was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, async):
  - FIFO emptied; pointers, fifo_count, buf_wr_en, tile_wr_done and overflow all 0.
  - buf_wr_adr and buf_wr_data read 0.
  - Rows in flight are discarded.
- Stage A, address calc, registered, 1 cycle:
  - adr = ((in_y_idx-1) << (of_in_2pow+ox_in_2pow-pixels_in_row_in_2pow)) + (((in_x_idx-1) << of_in_2pow) >> pixels_in_row_in_2pow) + (in_f_idx-1).
  - All terms use 16-bit unsigned arithmetic; the result is truncated to 16 bits.
  - of_in_2pow+ox_in_2pow must be >= pixels_in_row_in_2pow. If the sum is smaller, the shift amount saturates at 0.
  - Stage A captures {adr, in_data, in_tile_end} when in_valid=1.
- Stage B, FIFO push:
  - The stage-A output is pushed on the following cycle.
  - If the FIFO is full and no pop occurs that cycle, the entry is dropped and overflow is set; overflow stays set until reset.
  - Push and pop in the same cycle on a full FIFO succeeds; the count is unchanged.
- Output (show-ahead):
  - buf_wr_en = FIFO non-empty. buf_wr_adr/buf_wr_data come from the head entry.
  - A pop occurs when buf_wr_en && buf_wr_ready.
  - Head values hold stable while buf_wr_en=1 and buf_wr_ready=0.
- Latency: in_valid at cycle N with an empty FIFO gives buf_wr_en=1 at N+2. Throughput is 1 row/cycle when buf_wr_ready is held high.
- Tile done:
  - tile_wr_done is registered and asserts the cycle after the tile-end entry is popped, for exactly one cycle.
  - If the tile-end entry is dropped, no pulse is generated.
  - Back-to-back tiles each produce their own pulse.
- Wrap-around: pointers are modulo 2^fifo_depth_in_2pow; fifo_count ranges 0..2^fifo_depth_in_2pow.
- Small state machine for the tile-done path:
  - IDLE: no tile-end entry in the FIFO.
  - DRAIN: a tile-end entry is in the FIFO; moves to DONE on its pop.
  - DONE: one cycle, drives the pulse. Returns to DRAIN if another tile-end entry is queued, otherwise to IDLE.

Optional Feature:
- Macro: CONV_OUT_BUF_WRITER_ADR_CHECK_EN.
- When defined:
  - Stage A compares adr >= buf_depth.
  - An out-of-range row is not pushed and sets an extra sticky output adr_err (1 bit, reset 0).
  - If that row carried in_tile_end, the tile-end is still forwarded: a zero-data entry flagged "no write" is pushed. That entry pops without asserting buf_wr_en and still produces tile_wr_done.
- When not defined: no check and no adr_err port; every address is written as computed.

Test Plan:
1. of_in_2pow=4, ox_in_2pow=5; in_valid with y=2, x=1, f=3, buf_wr_ready=1 -> buf_wr_en at N+2 with buf_wr_adr=18 and data unchanged.
2. of_in_2pow=4, ox_in_2pow=6; y=1, x=33, f=1 -> buf_wr_adr=16. A burst of 16 rows f=1..16 -> addresses 16..31 on consecutive cycles.
3. buf_wr_ready=0, 10 consecutive valid rows, depth 8 -> fifo_count reaches 8, overflow=1, exactly 8 writes after ready rises, addresses equal to the first 8 rows.
4. A 3-row tile with tile_end on row 3, buf_wr_ready toggling 1010… -> tile_wr_done pulses once, the cycle after the third write handshake.
5. reset driven low asynchronously mid-burst with FIFO count 5 -> outputs 0 immediately; after release, no stale write, and a new row appears at N+2.
6. With CONV_OUT_BUF_WRITER_ADR_CHECK_EN, buf_depth=16, and a row addressing 18 with tile_end -> no buf_wr_en, adr_err=1, tile_wr_done pulses.
